// File: rtl/eq_coeff_bank.sv
// Double-buffered biquad coefficient store: equalizer reads the active bank, host fills the shadow.
// Optional EQ_COEFF_SHADOW_COPY_EN: after a swap, the new active bank is mirrored into the shadow.
module eq_coeff_bank #(
  parameter int unsigned NR_CHANNELS    = 3,
  parameter int unsigned NR_EQ_BANDS    = 8,
  parameter int unsigned EQ_COEFF_WIDTH = 32,
  localparam int unsigned NR_EQ_BAND_COEFF    = 5,
  localparam int unsigned NR_EQ_COEFF         = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF,
  localparam int unsigned EQ_COEFF_ADDR_WIDTH = $clog2(NR_EQ_COEFF)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [EQ_COEFF_ADDR_WIDTH-1:0] eq_coeff_addr,
  output logic [EQ_COEFF_WIDTH-1:0]      eq_coeff,
  input  logic [EQ_COEFF_WIDTH-1:0]      s_cfg_d,
  input  logic [EQ_COEFF_ADDR_WIDTH-1:0] s_cfg_addr,
  input  logic                           s_cfg_dv,
  output logic                           s_cfg_dr,
  input  logic                           cfg_commit,
  output logic                           swap_pending,
  output logic                           swap_done,
  output logic                           active_bank,
  output logic                           cfg_err
);

  localparam int unsigned AW = EQ_COEFF_ADDR_WIDTH;
  localparam int unsigned W  = EQ_COEFF_WIDTH;

  localparam logic [AW-1:0] LastIdx  = AW'(NR_EQ_COEFF - 1);
  localparam logic [AW:0]   NrCoeff  = (AW+1)'(NR_EQ_COEFF);
  localparam logic [W-1:0]  CoeffOne = {4'b0001, {(W-4){1'b0}}};

  typedef enum logic [1:0] {StInit, StIdle, StPending, StCopy} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [2:0]    mod_q, mod_d;
  logic          active_q, active_d;
  logic          pend_q, pend_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [W-1:0]  eq_coeff_q, eq_coeff_d;

  logic [W-1:0] mem [2][NR_EQ_COEFF];

  logic init_wr, host_wr, copy_wr, swap_now, rd_bank;
  logic rd_in_range, wr_in_range;

  assign rd_in_range = ({1'b0, eq_coeff_addr} < NrCoeff);
  assign wr_in_range = ({1'b0, s_cfg_addr} < NrCoeff);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mod_d    = mod_q;
    active_d = active_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    init_wr  = 1'b0;
    host_wr  = 1'b0;
    copy_wr  = 1'b0;
    swap_now = 1'b0;
    s_cfg_dr = 1'b0;
    case (state_q)
      StInit: begin
        init_wr = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        mod_d   = (mod_q == 3'd4) ? 3'd0 : mod_q + 3'd1;
        if (cnt_q == LastIdx) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      StIdle: begin
        s_cfg_dr = 1'b1;
        if (s_cfg_dv) begin
          if (wr_in_range) host_wr = 1'b1;
          else             err_d   = 1'b1;
        end
        if (cfg_commit) begin
          pend_d  = 1'b1;
          state_d = StPending;
        end
      end
      StPending: begin
        // Address 0 marks the start of an equalizer pass.
        if (eq_coeff_addr == '0) begin
          swap_now = 1'b1;
          active_d = ~active_q;
          pend_d   = 1'b0;
          done_d   = 1'b1;
`ifdef EQ_COEFF_SHADOW_COPY_EN
          cnt_d    = '0;
          state_d  = StCopy;
`else
          state_d  = StIdle;
`endif
        end
      end
`ifdef EQ_COEFF_SHADOW_COPY_EN
      StCopy: begin
        copy_wr = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StInit;
    endcase
    if (cfg_commit && state_q != StIdle) err_d = 1'b1;
  end

  // The swap cycle already reads the incoming bank.
  assign rd_bank = swap_now ? ~active_q : active_q;

  always_comb begin
    eq_coeff_d = '0;
    if (state_q != StInit && rd_in_range) eq_coeff_d = mem[rd_bank][eq_coeff_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      mod_q      <= '0;
      active_q   <= 1'b0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      eq_coeff_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mod_q      <= mod_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      err_q      <= err_d;
      eq_coeff_q <= eq_coeff_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (init_wr) begin
        mem[0][cnt_q] <= (mod_q == 3'd0) ? CoeffOne : '0;
        mem[1][cnt_q] <= (mod_q == 3'd0) ? CoeffOne : '0;
      end
      if (host_wr) mem[~active_q][s_cfg_addr] <= s_cfg_d;
      if (copy_wr) mem[~active_q][cnt_q] <= mem[active_q][cnt_q];
    end
  end

  assign eq_coeff     = eq_coeff_q;
  assign swap_pending = pend_q;
  assign swap_done    = done_q;
  assign active_bank  = active_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_eq_coeff_bank.sv
// Bench for eq_coeff_bank: directed sequence with random data, checked against a bank-level model.
// Honours EQ_COEFF_SHADOW_COPY_EN the same way as the design.
module tb_eq_coeff_bank;

  localparam int N  = 120;
  localparam int AW = 7;
  localparam logic [31:0] ONE = 32'h1000_0000;
`ifdef EQ_COEFF_SHADOW_COPY_EN
  localparam bit CopyEn = 1'b1;
`else
  localparam bit CopyEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] eq_coeff_addr = '0;
  logic [31:0]   eq_coeff;
  logic [31:0]   s_cfg_d = '0;
  logic [AW-1:0] s_cfg_addr = '0;
  logic          s_cfg_dv = 1'b0;
  logic          s_cfg_dr;
  logic          cfg_commit = 1'b0;
  logic          swap_pending, swap_done, active_bank, cfg_err;

  int checks = 0;
  int failures = 0;

  // Reference: two banks, which one is active, whether a swap is owed, remaining copy cycles.
  logic [31:0] ref_bank [2][N];
  bit          ref_act;
  bit          ref_pend;
  int          copy_left;
  int          dones;
  int          errs;

  eq_coeff_bank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .eq_coeff_addr(eq_coeff_addr),
    .eq_coeff     (eq_coeff),
    .s_cfg_d      (s_cfg_d),
    .s_cfg_addr   (s_cfg_addr),
    .s_cfg_dv     (s_cfg_dv),
    .s_cfg_dr     (s_cfg_dr),
    .cfg_commit   (cfg_commit),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .active_bank  (active_bank),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input bit b, input int a);
    return (a < N) ? ref_bank[b][a] : 32'h0;
  endfunction

  // One clock with the inputs currently driven; model updated first, outputs checked after the edge.
  task automatic cycle();
    bit          idle, exp_err, exp_done, exp_dr;
    logic [31:0] exp_q;
    exp_err  = 1'b0;
    exp_done = 1'b0;
    idle     = !ref_pend && copy_left == 0;
    if (s_cfg_dv && idle) begin
      if (int'(s_cfg_addr) < N) ref_bank[~ref_act][s_cfg_addr] = s_cfg_d;
      else exp_err = 1'b1;
    end
    if (cfg_commit && !idle) exp_err = 1'b1;
    if (copy_left > 0) copy_left--;
    if (ref_pend && eq_coeff_addr == '0) begin
      ref_act  = ~ref_act;
      ref_pend = 1'b0;
      exp_done = 1'b1;
      if (CopyEn) begin
        for (int i = 0; i < N; i++) ref_bank[~ref_act][i] = ref_bank[ref_act][i];
        copy_left = N;
      end
    end
    if (cfg_commit && idle) ref_pend = 1'b1;
    exp_q  = ref_read(ref_act, int'(eq_coeff_addr));
    step();
    exp_dr = !ref_pend && copy_left == 0;
    chk("eq_coeff", eq_coeff, exp_q);
    chk("swap_done", 32'(swap_done), 32'(exp_done));
    chk("swap_pending", 32'(swap_pending), 32'(ref_pend));
    chk("active_bank", 32'(active_bank), 32'(ref_act));
    chk("cfg_err", 32'(cfg_err), 32'(exp_err));
    chk("s_cfg_dr", 32'(s_cfg_dr), 32'(exp_dr));
    dones += int'(swap_done);
    errs  += int'(cfg_err);
  endtask

  task automatic reset_and_init();
    int bad;
    rst_n      = 1'b0;
    s_cfg_dv   = 1'b0;
    cfg_commit = 1'b0;
    step();
    step();
    chk("rst_dr", 32'(s_cfg_dr), 32'h0);
    chk("rst_pending", 32'(swap_pending), 32'h0);
    chk("rst_done", 32'(swap_done), 32'h0);
    chk("rst_active", 32'(active_bank), 32'h0);
    chk("rst_err", 32'(cfg_err), 32'h0);
    chk("rst_coeff", eq_coeff, 32'h0);
    for (int i = 0; i < N; i++) begin
      ref_bank[0][i] = (i % 5 == 0) ? ONE : 32'h0;
      ref_bank[1][i] = ref_bank[0][i];
    end
    ref_act   = 1'b0;
    ref_pend  = 1'b0;
    copy_left = 0;
    rst_n     = 1'b1;
    eq_coeff_addr = '0;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (s_cfg_dr !== 1'b0 || eq_coeff !== 32'h0 || swap_done !== 1'b0) bad++;
      step();
    end
    chk("init_busy_cycles", bad, 0);
    chk("init_exit_dr", 32'(s_cfg_dr), 32'h1);
  endtask

  task automatic host_wr(input int a, input logic [31:0] d, input bit commit);
    s_cfg_dv   = 1'b1;
    s_cfg_addr = AW'(a);
    s_cfg_d    = d;
    cfg_commit = commit;
    cycle();
    s_cfg_dv   = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic rd(input int a);
    eq_coeff_addr = AW'(a);
    cycle();
  endtask

  task automatic sweep(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      eq_coeff_addr = AW'((start + i) % N);
      cycle();
    end
  endtask

  initial begin
    dones = 0;
    errs  = 0;
    reset_and_init();

    // Identity after init, plus random and out-of-range reads.
    rd(0);   chk("t1_a0", eq_coeff, ONE);
    rd(1);   chk("t1_a1", eq_coeff, 32'h0);
    rd(5);   chk("t1_a5", eq_coeff, ONE);
    rd(127); chk("t1_oor", eq_coeff, 32'h0);
    for (int i = 0; i < 20; i++) rd(int'($urandom_range(127, 0)));

    // a0 = 1.5 plus random shadow writes; last write shares its cycle with the commit and addr 0.
    eq_coeff_addr = AW'(3);
    host_wr(0, 32'h1800_0000, 1'b0);
    for (int i = 0; i < 6; i++) host_wr(int'($urandom_range(119, 10)), $urandom, 1'b0);
    eq_coeff_addr = '0;
    host_wr(int'($urandom_range(119, 10)), $urandom, 1'b1);
    chk("t2_pending", 32'(swap_pending), 32'h1);
    chk("t2_no_same_cycle_swap", 32'(active_bank), 32'h0);

    // Second commit while pending.
    eq_coeff_addr = AW'(3);
    cycle();
    errs = 0;
    dones = 0;
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
    cycle();
    cycle();
    chk("t3_err_pulses", errs, 1);
    sweep(40, 240);
    chk("t2_swap_dones", dones, 1);
    chk("t2_active", 32'(active_bank), 32'h1);
    rd(0); chk("t2_new_a0", eq_coeff, 32'h1800_0000);

    // Delta edit of addr 5 only.
    dones = 0;
    host_wr(5, 32'h0800_0000, 1'b1);
    sweep(1, 260);
    chk("t5_swap_dones", dones, 1);
    rd(0); chk("t5_a0", eq_coeff, CopyEn ? 32'h1800_0000 : ONE);
    rd(5); chk("t5_a5", eq_coeff, 32'h0800_0000);

    // Out-of-range writes are consumed, flagged, and corrupt nothing.
    errs = 0;
    host_wr(120, 32'hDEAD_BEEF, 1'b0);
    host_wr(127, $urandom, 1'b0);
    chk("t4_err_pulses", errs, 2);
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
    sweep(60, 260);
    for (int a = 0; a < N; a++) rd(a);
    chk("t4_active", 32'(active_bank), 32'h1);

    // Reset while a swap is owed.
    eq_coeff_addr = AW'(7);
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
    cycle();
    chk("t6_pend_before", 32'(swap_pending), 32'h1);
    rst_n = 1'b0;
    step();
    chk("t6_pending", 32'(swap_pending), 32'h0);
    chk("t6_active", 32'(active_bank), 32'h0);
    reset_and_init();
    dones = 0;
    sweep(0, 130);
    chk("t6_no_swap", dones, 0);
    rd(0);   chk("t6_a0", eq_coeff, ONE);
    rd(115); chk("t6_a115", eq_coeff, ONE);
    rd(116); chk("t6_a116", eq_coeff, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
